prog_tick_timer: RTL and testbench
==================================

// Module: prog_tick_timer
// PURPOSE
//  Programmable timer/counter with tick output. Successor of the basic threshold counter:
//  adds a prescaler, up/down counting, periodic or one-shot mode, synchronous load,
//  start/stop control and a sticky interrupt flag. Used as the shared timebase for
//  baud, debounce and PWM blocks. One clock domain, single channel.
// PARAMETERS
//  WIDTH        8    counter, threshold and load_value width (>=2)
//  PRE_WIDTH    4    prescaler width; a step occurs every (prescale+1) en-cycles
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-high; clears all state
//  en          in   1          count enable; gates the prescaler only
//  start       in   1          pulse: IDLE/DONE -> RUN, loads start value
//  stop        in   1          pulse: RUN -> IDLE, count holds
//  load        in   1          pulse: count <= load_value, any state
//  load_value  in   WIDTH      value for load
//  dir         in   1          0 = up, 1 = down
//  one_shot    in   1          0 = periodic, 1 = one-shot
//  threshold   in   WIDTH      terminal value (up) / reload value (down)
//  prescale    in   PRE_WIDTH  step divider
//  irq_clr     in   1          clears irq
//  count       out  WIDTH      current count (registered)
//  tick        out  1          1-cycle pulse on terminal step (registered)
//  busy        out  1          1 while state == RUN
//  done        out  1          1 while state == DONE
//  irq         out  1          sticky; set by tick
// BEHAVIOUR
//  - Reset: state IDLE, count 0, prescaler 0, tick/busy/done/irq 0.
//  - FSM: IDLE -start-> RUN; RUN -stop-> IDLE; RUN -terminal step & one_shot-> DONE;
//    DONE -start-> RUN; DONE -stop-> IDLE. All other inputs leave state unchanged.
//  - Priority per cycle: load > start > stop > step. load and start also clear the
//    prescaler. load+start same cycle: count <= load_value, state -> RUN.
//  - start value: 0 if dir=0, threshold if dir=1.
//  - Prescaler: counts only when RUN and en. step = RUN & en & (pre_cnt == prescale);
//    on step pre_cnt <= 0, else pre_cnt+1. prescale=0 -> step every en-cycle.
//  - Terminal: up: count == threshold; down: count == 0. Compare uses the current
//    threshold input, sampled at the step.
//  - On non-terminal step: count +1 (up) / -1 (down), modulo 2^WIDTH.
//  - On terminal step: tick <= 1 next cycle (high exactly one cycle);
//    periodic: count reloads (up -> 0, down -> threshold), stays RUN;
//    one-shot: count holds terminal value, state -> DONE.
//  - Latency: count and tick update on the clock edge that consumes the step; tick
//    is high in the same cycle count shows the reloaded value.
//  - count beyond threshold (after load/threshold change) in up mode: counts to
//    2^WIDTH-1, wraps to 0, continues until threshold is hit. No tick on natural wrap.
//  - threshold = 0, up: every step is terminal (tick per step, count stays 0).
//  - dir change while RUN takes effect at the next step; no reload.
//  - irq: set on tick; irq_clr clears; tick and irq_clr same cycle -> irq stays 1.
//  - stop then start: count reloads start value; stop alone holds count.
//  - reset mid-run: immediate return to reset values, no tick emitted.
// TESTING
//  1 WIDTH=8, prescale=0, up, periodic, threshold=5, start, en=1 -> count 0..5,0,..;
//    tick 1 cycle each time count returns to 0, period 6 cycles; busy=1.
//  2 prescale=3, threshold=2, up -> count increments every 4 cycles; tick period 12.
//  3 down, one_shot, threshold=3, start -> count 3,2,1,0; tick once; done=1, busy=0,
//    count holds 0; second start -> runs again.
//  4 load_value=250, threshold=4, up -> 250..255,0..4, tick only at 4->0; irq set;
//    irq_clr with simultaneous tick -> irq remains 1.
//  5 en toggled 0 mid-run -> count and prescaler freeze; stop -> busy=0, count held;
//    load+start same cycle -> count=load_value, RUN.
//  6 assert reset mid-run with count=3 -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/prog_tick_timer_if.sv
// Control and status bundle for prog_tick_timer.
// The master drives the controls and the slave (the timer) drives the status.
interface prog_tick_timer_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRE_WIDTH = 4
);
  logic                 en;
  logic                 start;
  logic                 stop;
  logic                 load;
  logic [WIDTH-1:0]     load_value;
  logic                 dir;
  logic                 one_shot;
  logic [WIDTH-1:0]     threshold;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 irq_clr;
  logic [WIDTH-1:0]     count;
  logic                 tick;
  logic                 busy;
  logic                 done;
  logic                 irq;

  modport master (
    output en, start, stop, load, load_value, dir, one_shot, threshold, prescale, irq_clr,
    input  count, tick, busy, done, irq
  );

  modport slave (
    input  en, start, stop, load, load_value, dir, one_shot, threshold, prescale, irq_clr,
    output count, tick, busy, done, irq
  );
endinterface

// File: rtl/prog_tick_timer.sv
// Programmable tick timer: prescaled up/down counter with periodic or one-shot
// operation, synchronous load, start/stop control and a sticky interrupt flag.
module prog_tick_timer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  prog_tick_timer_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0]     CountOne = WIDTH'(1);
  localparam logic [PRE_WIDTH-1:0] PreOne   = PRE_WIDTH'(1);

  state_e               state_q;
  logic [WIDTH-1:0]     count_q;
  logic [PRE_WIDTH-1:0] pre_q;
  logic                 tick_q;
  logic                 irq_q;

  logic             run;
  logic             start_ok;
  logic             stop_ok;
  logic             pre_hit;
  logic             terminal;
  logic [WIDTH-1:0] start_val;

  // Decode of current state and the step/terminal conditions.
  always_comb begin
    run       = (state_q == StRun);
    start_ok  = bus_io.start & (state_q != StRun);
    stop_ok   = bus_io.stop & (state_q != StIdle);
    pre_hit   = (pre_q == bus_io.prescale);
    terminal  = bus_io.dir ? (count_q == '0) : (count_q == bus_io.threshold);
    start_val = bus_io.dir ? bus_io.threshold : '0;
  end

  // FSM, counter, prescaler and registered tick/irq in one sequential block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      // A tick being shown holds irq against a coincident clear.
      irq_q  <= (irq_q & ~bus_io.irq_clr) | tick_q;
      if (bus_io.load) begin
        count_q <= bus_io.load_value;
        pre_q   <= '0;
        if (start_ok) begin
          state_q <= StRun;
        end else if (stop_ok) begin
          state_q <= StIdle;
        end
      end else if (start_ok) begin
        count_q <= start_val;
        pre_q   <= '0;
        state_q <= StRun;
      end else if (stop_ok) begin
        state_q <= StIdle;
      end else if (run && bus_io.en) begin
        if (pre_hit) begin
          pre_q <= '0;
          if (terminal) begin
            tick_q <= 1'b1;
            irq_q  <= 1'b1;
            if (bus_io.one_shot) begin
              state_q <= StDone;
            end else begin
              count_q <= start_val;
            end
          end else begin
            count_q <= bus_io.dir ? (count_q - CountOne) : (count_q + CountOne);
          end
        end else begin
          pre_q <= pre_q + PreOne;
        end
      end
    end
  end

  assign bus_io.count = count_q;
  assign bus_io.tick  = tick_q;
  assign bus_io.busy  = (state_q == StRun);
  assign bus_io.done  = (state_q == StDone);
  assign bus_io.irq   = irq_q;

endmodule

// File: tb/tb_prog_tick_timer.sv
// Scoreboard bench for prog_tick_timer: the stimulus pushes the hand-derived
// expected outputs for each clock edge and a monitor pops and compares them.
module tb_prog_tick_timer;

  logic clk = 1'b0;
  logic reset;

  prog_tick_timer_if #(.WIDTH(8), .PRE_WIDTH(4)) bus ();

  prog_tick_timer #(.WIDTH(8), .PRE_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       done;
    logic       irq;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   total  = 0;
  int   passed = 0;

  // Drive one cycle of pulses and queue what must be visible after that edge.
  task automatic cyc(input logic ld, input logic st, input logic sp, input logic clr,
                     input logic [7:0] c, input logic t, input logic b, input logic d,
                     input logic i, input string nm);
    exp_t e;
    @(negedge clk);
    bus.load    = ld;
    bus.start   = st;
    bus.stop    = sp;
    bus.irq_clr = clr;
    e.count = c;
    e.tick  = t;
    e.busy  = b;
    e.done  = d;
    e.irq   = i;
    e.name  = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input logic [11:0] got, input logic [11:0] want, input string nm);
    total++;
    if (got !== want) begin
      $display("FAIL %s: got {count,tick,busy,done,irq}=%h want %h", nm, got, want);
    end else begin
      passed++;
    end
  endtask

  // Monitor: compares outputs shortly after each edge whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if ({bus.count, bus.tick, bus.busy, bus.done, bus.irq} !==
            {e.count, e.tick, e.busy, e.done, e.irq}) begin
          $display("FAIL %s @%0t: got count=%0d tick=%b busy=%b done=%b irq=%b, want count=%0d tick=%b busy=%b done=%b irq=%b",
                   e.name, $time, bus.count, bus.tick, bus.busy, bus.done, bus.irq,
                   e.count, e.tick, e.busy, e.done, e.irq);
        end else begin
          passed++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = 8'd0;
    bus.dir        = 1'b0;
    bus.one_shot   = 1'b0;
    bus.threshold  = 8'd0;
    bus.prescale   = 4'd0;
    bus.irq_clr    = 1'b0;
    #3;
    check_now({bus.count, bus.tick, bus.busy, bus.done, bus.irq}, 12'h000, "reset_state");
    #9;
    reset = 1'b0;

    // 1: up, periodic, prescale 0, threshold 5 -> period 6.
    bus.threshold = 8'd5;
    bus.en        = 1'b1;
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 0, "idle_after_reset");
    cyc(0, 1, 0, 0, 8'd0, 0, 1, 0, 0, "t1_start");
    for (int i = 1; i <= 13; i++)
      cyc(0, 0, 0, 0, 8'(i % 6), (i % 6 == 0), 1, 0, (i >= 6), "t1_run");
    cyc(0, 0, 1, 0, 8'd1, 0, 0, 0, 1, "t1_stop_holds");
    cyc(0, 0, 0, 1, 8'd1, 0, 0, 0, 0, "t1_irq_clr");

    // 2: prescale 3, threshold 2 -> step every 4, tick every 12.
    bus.prescale  = 4'd3;
    bus.threshold = 8'd2;
    cyc(0, 1, 0, 0, 8'd0, 0, 1, 0, 0, "t2_start");
    for (int j = 1; j <= 24; j++)
      cyc(0, 0, 0, 0, 8'((j / 4) % 3), (j % 12 == 0), 1, 0, (j >= 12), "t2_run");
    cyc(0, 0, 1, 0, 8'd0, 0, 0, 0, 1, "t2_stop");
    cyc(0, 0, 0, 1, 8'd0, 0, 0, 0, 0, "t2_irq_clr");

    // 3: down, one-shot, threshold 3.
    bus.prescale  = 4'd0;
    bus.dir       = 1'b1;
    bus.one_shot  = 1'b1;
    bus.threshold = 8'd3;
    cyc(0, 1, 0, 0, 8'd3, 0, 1, 0, 0, "t3_start");
    cyc(0, 0, 0, 0, 8'd2, 0, 1, 0, 0, "t3_cnt2");
    cyc(0, 0, 0, 0, 8'd1, 0, 1, 0, 0, "t3_cnt1");
    cyc(0, 0, 0, 0, 8'd0, 0, 1, 0, 0, "t3_cnt0");
    cyc(0, 0, 0, 0, 8'd0, 1, 0, 1, 1, "t3_done_tick");
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 1, 1, "t3_done_hold");
    cyc(0, 1, 0, 0, 8'd3, 0, 1, 0, 1, "t3_restart");
    cyc(0, 0, 0, 0, 8'd2, 0, 1, 0, 1, "t3_r_cnt2");
    cyc(0, 0, 0, 0, 8'd1, 0, 1, 0, 1, "t3_r_cnt1");
    cyc(0, 0, 0, 0, 8'd0, 0, 1, 0, 1, "t3_r_cnt0");
    cyc(0, 0, 0, 0, 8'd0, 1, 0, 1, 1, "t3_r_done_tick");
    cyc(0, 0, 1, 0, 8'd0, 0, 0, 0, 1, "t3_stop_from_done");
    cyc(0, 0, 0, 1, 8'd0, 0, 0, 0, 0, "t3_irq_clr");

    // 4: load 250 beyond threshold 4 -> wraps with no tick, ticks at 4->0.
    bus.dir        = 1'b0;
    bus.one_shot   = 1'b0;
    bus.threshold  = 8'd4;
    bus.load_value = 8'd250;
    cyc(1, 1, 0, 0, 8'd250, 0, 1, 0, 0, "t4_load_start");
    for (int j = 1; j <= 10; j++)
      cyc(0, 0, 0, 0, 8'(250 + j), 0, 1, 0, 0, "t4_run");
    cyc(0, 0, 0, 0, 8'd0, 1, 1, 0, 1, "t4_tick");
    cyc(0, 0, 0, 1, 8'd1, 0, 1, 0, 1, "t4_clr_with_tick");
    cyc(0, 0, 0, 1, 8'd2, 0, 1, 0, 0, "t4_clr");
    cyc(0, 0, 1, 0, 8'd2, 0, 0, 0, 0, "t4_stop");

    // 5: en freeze with prescale 1, stop hold, load+start.
    bus.prescale  = 4'd1;
    bus.threshold = 8'd9;
    cyc(0, 1, 0, 0, 8'd0, 0, 1, 0, 0, "t5_start");
    cyc(0, 0, 0, 0, 8'd0, 0, 1, 0, 0, "t5_pre1");
    cyc(0, 0, 0, 0, 8'd1, 0, 1, 0, 0, "t5_step1");
    cyc(0, 0, 0, 0, 8'd1, 0, 1, 0, 0, "t5_pre1b");
    bus.en = 1'b0;
    for (int j = 0; j < 3; j++)
      cyc(0, 0, 0, 0, 8'd1, 0, 1, 0, 0, "t5_en_low_freeze");
    bus.en = 1'b1;
    cyc(0, 0, 0, 0, 8'd2, 0, 1, 0, 0, "t5_pre_frozen_step");
    cyc(0, 0, 0, 0, 8'd2, 0, 1, 0, 0, "t5_pre1c");
    cyc(0, 0, 1, 0, 8'd2, 0, 0, 0, 0, "t5_stop");
    cyc(0, 0, 0, 0, 8'd2, 0, 0, 0, 0, "t5_idle_hold");
    cyc(0, 0, 0, 0, 8'd2, 0, 0, 0, 0, "t5_idle_hold");
    bus.load_value = 8'd7;
    cyc(1, 1, 0, 0, 8'd7, 0, 1, 0, 0, "t5_load_start");
    cyc(0, 0, 0, 0, 8'd7, 0, 1, 0, 0, "t5_after_load_pre");
    cyc(0, 0, 0, 0, 8'd8, 0, 1, 0, 0, "t5_after_load_step");
    cyc(0, 0, 1, 0, 8'd8, 0, 0, 0, 0, "t5_stop2");

    // threshold 0, up: every step is terminal.
    bus.prescale  = 4'd0;
    bus.threshold = 8'd0;
    cyc(0, 1, 0, 0, 8'd0, 0, 1, 0, 0, "th0_start");
    for (int j = 0; j < 3; j++)
      cyc(0, 0, 0, 0, 8'd0, 1, 1, 0, 1, "th0_tick_each_step");
    cyc(0, 0, 1, 0, 8'd0, 0, 0, 0, 1, "th0_stop");
    cyc(0, 0, 0, 1, 8'd0, 0, 0, 0, 0, "th0_irq_clr");

    // 6: asynchronous reset mid-run at count 3.
    bus.threshold = 8'd9;
    cyc(0, 1, 0, 0, 8'd0, 0, 1, 0, 0, "t6_start");
    cyc(0, 0, 0, 0, 8'd1, 0, 1, 0, 0, "t6_cnt1");
    cyc(0, 0, 0, 0, 8'd2, 0, 1, 0, 0, "t6_cnt2");
    cyc(0, 0, 0, 0, 8'd3, 0, 1, 0, 0, "t6_cnt3");
    #3;
    reset = 1'b1;
    #1;
    check_now({bus.count, bus.tick, bus.busy, bus.done, bus.irq}, 12'h000, "t6_async_reset");
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 0, "t6_idle_after_reset");
    cyc(0, 1, 0, 0, 8'd0, 0, 1, 0, 0, "t6_restart");
    cyc(0, 0, 0, 0, 8'd1, 0, 1, 0, 0, "t6_run_again");

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
    #3;
    if (sb_q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
